serializer_tx_arbiter: RTL

- Shares one byte-serializer between N_REQ byte producers with round-robin arbitration.
- Latches the winning byte, issues a one-cycle start to the serializer, then waits for its done pulse before the next grant.
- Sits between the producer ports and the serializer transmit input; the deserializer/check path on the far side is unaffected.

---
 rtl/serializer_arb_pkg.sv | 17 +
 rtl/serializer_tx_arbiter_rr_pick.sv | 31 +++
 rtl/serializer_tx_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/serializer_arb_pkg.sv
// Shared types for the serializer transmit arbiter: FSM states, default byte
// width and the grant-index width helper.
package serializer_arb_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serializer_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request bit searching
// from last+1 upward, wrapping modulo N_REQ.
module rr_pick
    import serializer_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int GW    = grant_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [GW-1:0]    last_i,
    output logic             valid_o,
    output logic [GW-1:0]    win_o
);

    logic [GW-1:0] idx;

    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        win_o = '0;
        idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = GW'((int'(last_i) + k) % N_REQ);
            if (req_i[idx]) begin
                win_o = idx;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/serializer_tx_arbiter.sv
// Round-robin arbiter sharing one byte serializer between N_REQ producers.
// Optional watchdog on the WAIT state is enabled with `define ARB_WDOG_EN.
module serializer_tx_arbiter
    import serializer_arb_pkg::*;
#(
    parameter  int N_REQ       = 4,
    parameter  int DATA_W      = DATA_W_DEF,
    parameter  int WDOG_CYCLES = 1024,
    localparam int GW          = grant_w(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    output logic                    ser_start,
    output logic [DATA_W-1:0]       ser_data,
    input  logic                    ser_busy,
    input  logic                    ser_done,
    output logic [GW-1:0]           grant_id,
    output logic                    arb_busy,
    output logic                    wdog_err
);

    arb_state_e        state_q;
    logic [N_REQ-1:0]  ack_q;
    logic              ser_start_q;
    logic              arb_busy_q;
    logic [DATA_W-1:0] ser_data_q;
    logic [GW-1:0]     grant_q;
    logic [GW-1:0]     last_q;
    logic [GW-1:0]     pick_win;
    logic              pick_valid;
    logic              launch;
    logic [DATA_W-1:0] byte_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
        assign byte_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .GW    (GW)
    ) u_rr_pick (
        .req_i   (req),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .win_o   (pick_win)
    );

    // A grant may be issued from IDLE, or straight out of WAIT on ser_done.
    assign launch = pick_valid && !ser_busy &&
                    ((state_q == ST_IDLE) || ((state_q == ST_WAIT) && ser_done));

`ifdef ARB_WDOG_EN
    localparam int             WCW       = $clog2(WDOG_CYCLES) + 1;
    localparam logic [WCW-1:0] WDOG_LAST = WCW'(WDOG_CYCLES - 1);
    logic [WCW-1:0] wdog_cnt_q;
    logic           wdog_err_q;
    assign wdog_err = wdog_err_q;
`else
    assign wdog_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ack_q       <= '0;
            ser_start_q <= 1'b0;
            arb_busy_q  <= 1'b0;
            ser_data_q  <= '0;
            grant_q     <= '0;
            last_q      <= GW'(N_REQ - 1);
`ifdef ARB_WDOG_EN
            wdog_cnt_q  <= '0;
            wdog_err_q  <= 1'b0;
`endif
        end else begin
            ack_q       <= '0;
            ser_start_q <= 1'b0;
            if (launch) begin
                ser_data_q  <= byte_arr[pick_win];
                grant_q     <= pick_win;
                ack_q       <= N_REQ'(1) << pick_win;
                ser_start_q <= 1'b1;
                arb_busy_q  <= 1'b1;
                state_q     <= ST_START;
            end else begin
                case (state_q)
                    ST_IDLE: ;
                    ST_START: begin
                        last_q  <= grant_q;
                        state_q <= ST_WAIT;
`ifdef ARB_WDOG_EN
                        wdog_cnt_q <= '0;
`endif
                    end
                    ST_WAIT: begin
                        if (ser_done) begin
                            state_q    <= ST_IDLE;
                            arb_busy_q <= 1'b0;
                        end
`ifdef ARB_WDOG_EN
                        else if (wdog_cnt_q == WDOG_LAST) begin
                            wdog_err_q <= 1'b1;
                            state_q    <= ST_IDLE;
                            arb_busy_q <= 1'b0;
                        end else begin
                            wdog_cnt_q <= wdog_cnt_q + 1'b1;
                        end
`endif
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        arb_busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ack       = ack_q;
    assign ser_start = ser_start_q;
    assign ser_data  = ser_data_q;
    assign grant_id  = grant_q;
    assign arb_busy  = arb_busy_q;

endmodule
